// File: rtl/one_unit_w_decision_if.sv
// Bus between the one-unit update datapath, the seed programmer and the
// weight-decision stage: seed bank writes, the update handshake and the
// decision outputs.
interface one_unit_w_decision_if #(
  parameter int N      = 4,
  parameter int W      = 26,
  parameter int ITER_W = 8
);
  localparam int AW = (N * N > 1) ? $clog2(N * N) : 1;

  logic                 start;
  logic                 seed_we;
  logic [AW-1:0]        seed_addr;
  logic [W-1:0]         seed_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [N*N*W-1:0]     iw_flat;
  logic [N*N*W-1:0]     ow_flat;
  logic [ITER_W-1:0]    iter_cnt;
  logic                 done;
  logic                 converged;
  logic                 timeout;

  modport master (
    output start, seed_we, seed_addr, seed_data, in_valid, iw_flat,
    input  in_ready, ow_flat, iter_cnt, done, converged, timeout
  );

  modport slave (
    input  start, seed_we, seed_addr, seed_data, in_valid, iw_flat,
    output in_ready, ow_flat, iter_cnt, done, converged, timeout
  );
endinterface

// File: rtl/one_unit_w_decision.sv
// FastICA one-unit weight-decision stage: holds the separating matrix W,
// reloads it from a programmable seed bank on start, accepts updated
// matrices and decides continue / converged / iteration-timeout.
module one_unit_w_decision #(
  parameter int N        = 4,
  parameter int W        = 26,
  parameter int FRAC     = 13,
  parameter int TOL      = 8,
  parameter int MAX_ITER = 255,
  parameter int ITER_W   = 8
) (
  input logic                   clk_b,
  input logic                   rstn_b,
  one_unit_w_decision_if.slave  bus
);
  localparam int NE = N * N;
  localparam int AW = (NE > 1) ? $clog2(NE) : 1;
  localparam int DW = W + 1;
  localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);
  localparam logic [DW-1:0]     TOL_V   = DW'(TOL);

  typedef enum logic [2:0] {IDLE, SEED, RUN, DECIDE, DONE} state_t;

  state_t              state;
  state_t              next_state;
  logic [W-1:0]        seed_bank [NE];
  logic [NE*W-1:0]     seed_flat;
  logic [NE*W-1:0]     ow;
  logic [ITER_W-1:0]   iter;
  logic                conv_flag;
  logic                done_r;
  logic                conv_r;
  logic                tmo_r;
  logic                in_ready_c;
  logic                accept;
  logic                addr_ok;
  logic                conv_now;
  logic [W-1:0]        nv;
  logic [W-1:0]        ov;
  logic [DW-1:0]       diff;
  logic [DW-1:0]       mag;

  // Address range check only matters when N*N is not a power of two.
  if (NE == (1 << AW)) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    assign addr_ok = (bus.seed_addr < AW'(NE));
  end

  // start wins over a same-cycle accept: the update is discarded.
  assign accept = in_ready_c & bus.in_valid & ~bus.start;

  // Seed bank: identity after reset, writable in any state.
  always_ff @(posedge clk_b or negedge rstn_b) begin
    if (!rstn_b) begin
      for (int unsigned i = 0; i < NE; i++) begin
        seed_bank[i] <= ((i / N) == (i % N)) ? (W'(1) << FRAC) : '0;
      end
    end else if (bus.seed_we && addr_ok) begin
      seed_bank[bus.seed_addr] <= bus.seed_data;
    end
  end

  // Flatten the seed bank into the ow_flat packing.
  always_comb begin
    seed_flat = '0;
    for (int unsigned i = 0; i < NE; i++) begin
      seed_flat[i*W +: W] = seed_bank[i];
    end
  end

  // Element-wise |new - old| <= TOL on W+1 bits so extremes never wrap.
  always_comb begin
    conv_now = 1'b1;
    nv       = '0;
    ov       = '0;
    diff     = '0;
    mag      = '0;
    for (int unsigned i = 0; i < NE; i++) begin
      nv   = bus.iw_flat[i*W +: W];
      ov   = ow[i*W +: W];
      diff = {nv[W-1], nv} - {ov[W-1], ov};
      mag  = diff[W] ? (-diff) : diff;
      if (mag > TOL_V) begin
        conv_now = 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_b or negedge rstn_b) begin
    if (!rstn_b) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = SEED;
      SEED:    next_state = RUN;
      RUN: begin
        if (bus.start)   next_state = SEED;
        else if (accept) next_state = DECIDE;
      end
      DECIDE: begin
        if (bus.start)                        next_state = SEED;
        else if (conv_flag || (iter == MAX_CNT)) next_state = DONE;
        else                                  next_state = RUN;
      end
      DONE:    if (bus.start) next_state = SEED;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: the handshake is open only while iterating.
  always_comb begin
    in_ready_c = 1'b0;
    if (state == RUN) begin
      in_ready_c = 1'b1;
    end
  end

  // Datapath: seed reload, update capture and decision flags.
  always_ff @(posedge clk_b or negedge rstn_b) begin
    if (!rstn_b) begin
      ow        <= '0;
      iter      <= '0;
      conv_flag <= 1'b0;
      done_r    <= 1'b0;
      conv_r    <= 1'b0;
      tmo_r     <= 1'b0;
    end else begin
      case (state)
        SEED: begin
          ow        <= seed_flat;
          iter      <= '0;
          conv_flag <= 1'b0;
          done_r    <= 1'b0;
          conv_r    <= 1'b0;
          tmo_r     <= 1'b0;
        end
        RUN: begin
          if (accept) begin
            ow        <= bus.iw_flat;
            iter      <= iter + 1'b1;
            conv_flag <= conv_now;
          end
        end
        DECIDE: begin
          if (!bus.start) begin
            if (conv_flag) begin
              done_r <= 1'b1;
              conv_r <= 1'b1;
            end else if (iter == MAX_CNT) begin
              done_r <= 1'b1;
              tmo_r  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.ow_flat   = ow;
  assign bus.iter_cnt  = iter;
  assign bus.done      = done_r;
  assign bus.converged = conv_r;
  assign bus.timeout   = tmo_r;

endmodule

// File: tb/tb_one_unit_w_decision.sv
// Directed bench for one_unit_w_decision (N=4, W=26, FRAC=13, TOL=8,
// MAX_ITER=3).
module tb_one_unit_w_decision;
  localparam int N      = 4;
  localparam int W      = 26;
  localparam int FRAC   = 13;
  localparam int TOL    = 8;
  localparam int ITER_W = 8;
  localparam int NE     = N * N;
  localparam int AW     = 4;

  logic clk_b;
  logic rstn_b;
  int   checks;
  int   failures;

  logic [NE*W-1:0] ident;
  logic [NE*W-1:0] z;
  logic [NE*W-1:0] m;

  one_unit_w_decision_if #(.N(N), .W(W), .ITER_W(ITER_W)) bus ();

  one_unit_w_decision #(
    .N(N), .W(W), .FRAC(FRAC), .TOL(TOL), .MAX_ITER(3), .ITER_W(ITER_W)
  ) u_dut (
    .clk_b  (clk_b),
    .rstn_b (rstn_b),
    .bus    (bus)
  );

  initial clk_b = 1'b0;
  always #5 clk_b = ~clk_b;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] ev(input int v);
    ev = W'(v);
  endfunction

  function automatic logic [NE*W-1:0] put(input logic [NE*W-1:0] mi,
                                          input int r, input int c,
                                          input logic [W-1:0] v);
    logic [NE*W-1:0] mo;
    mo = mi;
    mo[(r*N+c)*W +: W] = v;
    return mo;
  endfunction

  function automatic logic [W-1:0] el(input int r, input int c);
    el = bus.ow_flat[(r*N+c)*W +: W];
  endfunction

  task automatic check(input string tag, input logic [NE*W-1:0] obs,
                       input logic [NE*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_b);
    #1;
  endtask

  task automatic seed_wr(input int a, input logic [W-1:0] d);
    bus.seed_we   = 1'b1;
    bus.seed_addr = AW'(a);
    bus.seed_data = d;
    tick();
    bus.seed_we   = 1'b0;
  endtask

  task automatic do_start;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("seed_cycle_ready", {415'd0, bus.in_ready}, '0);
    tick();
    check("run_ready", {415'd0, bus.in_ready}, 1);
  endtask

  task automatic push(input logic [NE*W-1:0] mi);
    bus.in_valid = 1'b1;
    bus.iw_flat  = mi;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rstn_b        = 1'b0;
    bus.start     = 1'b0;
    bus.seed_we   = 1'b0;
    bus.seed_addr = '0;
    bus.seed_data = '0;
    bus.in_valid  = 1'b0;
    bus.iw_flat   = '0;
    z             = '0;
    ident         = '0;
    for (int i = 0; i < N; i++) ident = put(ident, i, i, ev(8192));

    // reset state
    repeat (2) tick();
    rstn_b = 1'b1;
    tick();
    check("rst_ow", bus.ow_flat, '0);
    check("rst_iter", {408'd0, bus.iter_cnt}, '0);
    check("rst_ready", {415'd0, bus.in_ready}, '0);
    check("rst_done", {415'd0, bus.done}, '0);
    check("rst_conv", {415'd0, bus.converged}, '0);
    check("rst_tmo", {415'd0, bus.timeout}, '0);

    // identity seed load
    do_start();
    check("ident_ow", bus.ow_flat, ident);

    // programmed seed, then push the same matrix -> converged
    seed_wr(0, ev(-1223));
    seed_wr(4, ev(20062));
    do_start();
    check("seed_el00", {390'd0, el(0, 0)}, {390'd0, ev(-1223)});
    check("seed_el10", {390'd0, el(1, 0)}, {390'd0, ev(20062)});
    check("seed_iter", {408'd0, bus.iter_cnt}, '0);
    m = put(put(ident, 0, 0, ev(-1223)), 1, 0, ev(20062));
    check("seed_ow", bus.ow_flat, m);
    push(m);
    check("same_iter", {408'd0, bus.iter_cnt}, 1);
    check("same_decide_ready", {415'd0, bus.in_ready}, '0);
    check("same_decide_done", {415'd0, bus.done}, '0);
    tick();
    check("same_done", {415'd0, bus.done}, 1);
    check("same_conv", {415'd0, bus.converged}, 1);
    check("same_tmo", {415'd0, bus.timeout}, '0);

    // tolerance boundary with a zero seed
    for (int i = 0; i < NE; i++) seed_wr(i, ev(0));
    do_start();
    check("zero_ow", bus.ow_flat, z);
    push(put(z, 2, 3, ev(8)));
    tick();
    check("tol8_conv", {415'd0, bus.converged}, 1);
    check("tol8_done", {415'd0, bus.done}, 1);
    do_start();
    push(put(z, 2, 3, ev(9)));
    tick();
    check("tol9_conv", {415'd0, bus.converged}, '0);
    check("tol9_done", {415'd0, bus.done}, '0);
    check("tol9_ready", {415'd0, bus.in_ready}, 1);
    push(put(z, 2, 3, ev(1)));
    tick();
    check("tolneg8_conv", {415'd0, bus.converged}, 1);
    check("tolneg8_iter", {408'd0, bus.iter_cnt}, 2);

    // extremes never wrap, then timeout after MAX_ITER=3
    seed_wr(0, ev(-33554432));
    do_start();
    check("ext_seed", {390'd0, el(0, 0)}, {390'd0, ev(-33554432)});
    push(put(z, 0, 0, ev(33554431)));
    tick();
    check("ext_conv", {415'd0, bus.converged}, '0);
    check("ext_done", {415'd0, bus.done}, '0);
    check("ext_ready", {415'd0, bus.in_ready}, 1);
    push(put(z, 0, 0, ev(-33554432)));
    tick();
    check("ext2_done", {415'd0, bus.done}, '0);
    push(put(z, 0, 0, ev(33554431)));
    check("tmo_iter_accept", {408'd0, bus.iter_cnt}, 3);
    tick();
    check("tmo_flag", {415'd0, bus.timeout}, 1);
    check("tmo_conv", {415'd0, bus.converged}, '0);
    check("tmo_done", {415'd0, bus.done}, 1);
    tick();
    check("tmo_hold", {415'd0, bus.done}, 1);
    check("tmo_ow_frozen", {390'd0, el(0, 0)}, {390'd0, ev(33554431)});

    // start in the same cycle as an accept discards the update
    do_start();
    push(put(z, 1, 1, ev(5)));
    tick();
    check("abort_pre_iter", {408'd0, bus.iter_cnt}, 1);
    bus.in_valid = 1'b1;
    bus.iw_flat  = put(z, 3, 3, ev(100));
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_iter_hold", {408'd0, bus.iter_cnt}, 1);
    check("abort_ow_hold", bus.ow_flat, put(z, 1, 1, ev(5)));
    tick();
    check("abort_iter_zero", {408'd0, bus.iter_cnt}, '0);
    check("abort_ow_seed", bus.ow_flat, put(z, 0, 0, ev(-33554432)));
    check("abort_ready", {415'd0, bus.in_ready}, 1);

    // reset in DECIDE clears everything at once
    seed_wr(5, ev(77));
    push(z);
    rstn_b = 1'b0;
    #1;
    check("mid_rst_ow", bus.ow_flat, '0);
    check("mid_rst_iter", {408'd0, bus.iter_cnt}, '0);
    check("mid_rst_ready", {415'd0, bus.in_ready}, '0);
    tick();
    rstn_b = 1'b1;
    bus.in_valid = 1'b1;
    bus.iw_flat  = put(z, 0, 0, ev(3));
    tick();
    bus.in_valid = 1'b0;
    check("post_rst_no_accept_iter", {408'd0, bus.iter_cnt}, '0);
    check("post_rst_no_accept_ow", bus.ow_flat, '0);
    do_start();
    check("post_rst_ident", bus.ow_flat, ident);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
